// File: rtl/alu_arbiter.sv
// Two-requester round-robin front end for a shared, multi-cycle combinational ALU.
// Latency: grant on E0, result/DONE at E0+WAIT_CYCLES, next grant no earlier than E0+WAIT_CYCLES+2.
// Backpressure: requests are level-held; a requester stays un-granted while BUSY and is served in IDLE.
module alu_arbiter #(
  parameter int WAIT_CYCLES = 2
) (
  input  logic       CLK,
  input  logic       RESETN,
  input  logic       REQ0,
  input  logic       REQ1,
  input  logic [7:0] OP0_A,
  input  logic [7:0] OP0_B,
  input  logic [7:0] OP1_A,
  input  logic [7:0] OP1_B,
  input  logic [2:0] SEL0,
  input  logic [2:0] SEL1,
  output logic       GNT0,
  output logic       GNT1,
  output logic       DONE0,
  output logic       DONE1,
  output logic [7:0] RESULT,
  output logic       ZERO,
  output logic       BUSY,
  output logic [7:0] ALU_DATA1,
  output logic [7:0] ALU_DATA2,
  output logic [2:0] ALU_SELECT,
  input  logic [7:0] ALU_RESULT,
  input  logic       ALU_ZERO
);

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    EXEC = 2'b01,
    RESP = 2'b10
  } state_t;

  localparam logic [3:0] WAIT_LD = 4'(WAIT_CYCLES);

  state_t     state;
  state_t     state_nxt;
  logic       last;     // most recent winner; doubles as owner of the op in flight
  logic [3:0] cnt;
  logic       win;
  logic       grant;
  logic       capture;

  // Round-robin pick: on contention the requester that did not win last time goes first
  always_comb begin
    win = REQ1;
    if (REQ0 && REQ1) win = ~last;
  end

  // Next-state decode plus the grant/capture strobes for the datapath
  always_comb begin
    state_nxt = state;
    grant     = 1'b0;
    capture   = 1'b0;
    case (state)
      IDLE: begin
        if (REQ0 || REQ1) begin
          grant     = 1'b1;
          state_nxt = EXEC;
        end
      end
      EXEC: begin
        // cnt is loaded with WAIT_CYCLES at grant, so reaching 1 marks the last EXEC cycle
        if (cnt == 4'd1) begin
          capture   = 1'b1;
          state_nxt = RESP;
        end
      end
      RESP:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // State register
  always_ff @(posedge CLK or negedge RESETN) begin
    if (!RESETN) state <= IDLE;
    else         state <= state_nxt;
  end

  // Operand latch, wait counter, result capture and one-cycle GNT/DONE pulses
  always_ff @(posedge CLK or negedge RESETN) begin
    if (!RESETN) begin
      last       <= 1'b1;
      cnt        <= 4'd0;
      GNT0       <= 1'b0;
      GNT1       <= 1'b0;
      DONE0      <= 1'b0;
      DONE1      <= 1'b0;
      RESULT     <= 8'h00;
      ZERO       <= 1'b0;
      ALU_DATA1  <= 8'h00;
      ALU_DATA2  <= 8'h00;
      ALU_SELECT <= 3'b000;
    end else begin
      GNT0  <= 1'b0;
      GNT1  <= 1'b0;
      DONE0 <= 1'b0;
      DONE1 <= 1'b0;
      if (grant) begin
        last       <= win;
        cnt        <= WAIT_LD;
        GNT0       <= ~win;
        GNT1       <= win;
        ALU_DATA1  <= win ? OP1_A : OP0_A;
        ALU_DATA2  <= win ? OP1_B : OP0_B;
        ALU_SELECT <= win ? SEL1  : SEL0;
      end else if (state == EXEC) begin
        if (capture) begin
          // Reserved opcodes still run the full timing but report a zero result
          RESULT <= ALU_SELECT[2] ? 8'h00 : ALU_RESULT;
          ZERO   <= ALU_ZERO;
          DONE0  <= ~last;
          DONE1  <= last;
          cnt    <= 4'd0;
        end else begin
          cnt <= cnt - 4'd1;
        end
      end
    end
  end

  assign BUSY = (state != IDLE);

endmodule

// File: tb/tb_alu_arbiter.sv
// Scoreboard bench for alu_arbiter with a behavioural model of the shared ALU.
// Stimulus pushes expected grants/responses; a negedge monitor pops and compares.
// The ALU model sets its zero flag when the two operands are equal.
module tb_alu_arbiter;

  localparam int W = 2;

  typedef struct {
    bit         id;
    logic [7:0] res;
    bit         zero;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       req0, req1;
  logic [7:0] op0_a, op0_b, op1_a, op1_b;
  logic [2:0] sel0, sel1;
  logic       gnt0, gnt1, done0, done1;
  logic [7:0] result;
  logic       zero;
  logic       busy;
  logic [7:0] alu_data1, alu_data2;
  logic [2:0] alu_select;
  logic [7:0] alu_result;
  logic       alu_zero;

  int n_chk  = 0;
  int n_fail = 0;
  int cyc    = 0;
  int last_gnt_cyc = 0;

  bit   gnt_q[$];
  exp_t done_q[$];
  int   gnt_cycs[$];

  alu_arbiter #(.WAIT_CYCLES(W)) dut (
    .CLK(clk), .RESETN(rst_n),
    .REQ0(req0), .REQ1(req1),
    .OP0_A(op0_a), .OP0_B(op0_b), .OP1_A(op1_a), .OP1_B(op1_b),
    .SEL0(sel0), .SEL1(sel1),
    .GNT0(gnt0), .GNT1(gnt1), .DONE0(done0), .DONE1(done1),
    .RESULT(result), .ZERO(zero), .BUSY(busy),
    .ALU_DATA1(alu_data1), .ALU_DATA2(alu_data2), .ALU_SELECT(alu_select),
    .ALU_RESULT(alu_result), .ALU_ZERO(alu_zero)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc++;

  // Shared ALU model; reserved opcodes return A+B so a missing force-to-zero is visible
  always_comb begin
    alu_result = alu_data1 + alu_data2;
    case (alu_select)
      3'b000:  alu_result = alu_data2;
      3'b001:  alu_result = alu_data1 + alu_data2;
      3'b010:  alu_result = alu_data1 & alu_data2;
      3'b011:  alu_result = alu_data1 | alu_data2;
      default: alu_result = alu_data1 + alu_data2;
    endcase
    alu_zero = (alu_data1 == alu_data2);
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Monitor: compares every GNT/DONE pulse against the scoreboard queues
  always @(negedge clk) begin
    if (rst_n) begin
      if (gnt0 || gnt1) begin
        check("gnt_no_overlap", {31'd0, gnt0 && gnt1}, 32'd0);
        if (gnt_q.size() == 0) begin
          check("unexpected_gnt", 32'd1, 32'd0);
        end else begin
          bit e;
          e = gnt_q.pop_front();
          check("gnt_id", {31'd0, gnt1}, {31'd0, e});
        end
        last_gnt_cyc = cyc;
        gnt_cycs.push_back(cyc);
      end
      if (done0 || done1) begin
        check("done_no_overlap", {31'd0, done0 && done1}, 32'd0);
        if (done_q.size() == 0) begin
          check("unexpected_done", 32'd1, 32'd0);
        end else begin
          exp_t e;
          e = done_q.pop_front();
          check("done_id", {31'd0, done1}, {31'd0, e.id});
          check("result", {24'd0, result}, {24'd0, e.res});
          check("zero", {31'd0, zero}, {31'd0, e.zero});
          check("done_latency", cyc - last_gnt_cyc, W);
        end
      end
    end
  end

  task automatic set_req(input bit id, input bit v);
    if (id) req1 = v;
    else    req0 = v;
  endtask

  task automatic set_ops(input bit id, input [7:0] a, input [7:0] b, input [2:0] s);
    if (id) begin op1_a = a; op1_b = b; sel1 = s; end
    else    begin op0_a = a; op0_b = b; sel0 = s; end
  endtask

  task automatic wait_drain();
    for (int i = 0; i < 60 && (done_q.size() != 0 || gnt_q.size() != 0); i++) @(negedge clk);
    if (done_q.size() != 0 || gnt_q.size() != 0) begin
      check("drain_timeout", done_q.size() + gnt_q.size(), 0);
      done_q.delete();
      gnt_q.delete();
    end
    @(negedge clk);
  endtask

  task automatic check_reset_outputs(input string name);
    check(name, {gnt0, gnt1, done0, done1, busy, zero, result, alu_data1, alu_data2, alu_select},
          32'd0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    check_reset_outputs("reset_state");
    rst_n = 1'b1;
  endtask

  task automatic issue(input bit id, input [7:0] a, input [7:0] b, input [2:0] s,
                       input [7:0] er, input bit ez);
    exp_t e;
    @(negedge clk);
    set_ops(id, a, b, s);
    set_req(id, 1'b1);
    e.id = id; e.res = er; e.zero = ez;
    gnt_q.push_back(id);
    done_q.push_back(e);
    @(negedge clk);
    set_req(id, 1'b0);
    check("busy_in_exec", {31'd0, busy}, 32'd1);
    wait_drain();
  endtask

  initial begin
    exp_t e;
    rst_n = 1'b0;
    req0 = 1'b0; req1 = 1'b0;
    op0_a = 8'h00; op0_b = 8'h00; op1_a = 8'h00; op1_b = 8'h00;
    sel0 = 3'b000; sel1 = 3'b000;
    #1 check_reset_outputs("reset_async");
    do_reset();

    // Basic add on requester 0
    issue(1'b0, 8'd5, 8'd3, 3'b001, 8'h08, 1'b0);
    // Signed wrap and forward-B on requester 1
    issue(1'b1, 8'h7F, 8'h01, 3'b001, 8'h80, 1'b0);
    issue(1'b1, 8'h22, 8'h22, 3'b000, 8'h22, 1'b1);
    // Reserved opcode: result forced to zero, zero flag from the ALU
    issue(1'b0, 8'd9, 8'd9, 3'b101, 8'h00, 1'b1);

    // Operands change right after the grant; the in-flight op must keep the latched ones
    @(negedge clk);
    set_ops(1'b0, 8'h10, 8'h20, 3'b011);
    req0 = 1'b1;
    gnt_q.push_back(1'b0);
    e.id = 1'b0; e.res = 8'h30; e.zero = 1'b0;
    done_q.push_back(e);
    @(negedge clk);
    req0 = 1'b0;
    set_ops(1'b0, 8'hFF, 8'hFF, 3'b000);
    @(negedge clk);
    check("hold_data1", {24'd0, alu_data1}, 32'h10);
    check("hold_data2", {24'd0, alu_data2}, 32'h20);
    check("hold_select", {29'd0, alu_select}, 32'd3);
    wait_drain();

    // Both requesters held high after reset: 0,1,0,1 every W+2 cycles
    do_reset();
    gnt_cycs.delete();
    @(negedge clk);
    set_ops(1'b0, 8'hF0, 8'h3C, 3'b010);
    set_ops(1'b1, 8'h0F, 8'h0F, 3'b010);
    req0 = 1'b1; req1 = 1'b1;
    for (int k = 0; k < 4; k++) begin
      gnt_q.push_back(k[0]);
      e.id = k[0];
      e.res = k[0] ? 8'h0F : 8'h30;
      e.zero = k[0];
      done_q.push_back(e);
    end
    repeat (14) @(negedge clk);
    req0 = 1'b0; req1 = 1'b0;
    wait_drain();
    check("rr_grant_count", gnt_cycs.size(), 4);
    for (int k = 1; k < gnt_cycs.size(); k++)
      check("rr_spacing", gnt_cycs[k] - gnt_cycs[k-1], W + 2);

    // Reset one cycle into EXEC: outputs clear at once and the op never completes
    @(negedge clk);
    set_ops(1'b0, 8'd1, 8'd2, 3'b001);
    req0 = 1'b1;
    gnt_q.push_back(1'b0);
    @(negedge clk);
    req0 = 1'b0;
    check("busy_before_abort", {31'd0, busy}, 32'd1);
    #1 rst_n = 1'b0;
    #1 check_reset_outputs("abort_async");
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (6) @(negedge clk);
    check("abort_grant_seen", gnt_q.size(), 0);
    check_reset_outputs("abort_no_done");
    issue(1'b0, 8'd4, 8'd4, 3'b001, 8'h08, 1'b1);

    check("queues_empty", gnt_q.size() + done_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
